// File: rtl/motion_pkg.sv
// Shared types, widths and saturation helpers for the line-follower motion controller.
package motion_pkg;

  localparam int unsigned ACC_W  = 16;
  localparam int unsigned ERR_W  = 12;
  localparam int unsigned MTR_W  = 11;
  localparam int unsigned GAIN_W = 4;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned RES_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CNV_R,
    ST_GAP,
    ST_CNV_L,
    ST_NEXT,
    ST_PI_MUL,
    ST_MTR
  } state_t;

  // Clamp a wide signed value into the 16b accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [31:0] v);
    if (v > 32'sd32767) return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    return v[ACC_W-1:0];
  endfunction

  // Clamp into the 12b error/integrator/correction range.
  function automatic logic signed [ERR_W-1:0] sat12(input logic signed [31:0] v);
    if (v > 32'sd2047) return 12'sh7FF;
    else if (v < -32'sd2048) return 12'sh800;
    return v[ERR_W-1:0];
  endfunction

  // Clamp into the 11b motor duty range.
  function automatic logic signed [MTR_W-1:0] sat11(input logic signed [31:0] v);
    if (v > 32'sd1023) return 11'sh3FF;
    else if (v < -32'sd1024) return 11'sh400;
    return v[MTR_W-1:0];
  endfunction

endpackage

// File: rtl/pi_mul.sv
// Shared signed 12b x unsigned 4b multiplier, registered output, 1-clk latency.
//  clk, rst_n : clock, async active-low reset
//  a          : signed operand (error or integrator)
//  b          : unsigned gain
//  prod       : registered signed product a*b
module pi_mul
  import motion_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [ERR_W-1:0]  a,
  input  logic        [GAIN_W-1:0] b,
  output logic signed [PROD_W-1:0] prod
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign a_ext = PROD_W'(a);
  assign b_ext = $signed(PROD_W'(b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod <= '0;
    else        prod <= a_ext * b_ext;
  end

endmodule

// File: rtl/pid_motion_cntrl.sv
// Line-follower motion controller: sweeps N_PAIRS IR pairs through the shared A2D,
// forms a weighted left-minus-right error, applies a PI law and updates motor duties.
// Optional integrator enabled by defining MOTION_INTG_EN (P-only when undefined).
//  go        : run enable, sampled in IDLE
//  strt_cnv  : one-clk A2D start pulse;  cnv_cmplt/A2D_res : A2D done + result
//  chnnl     : A2D channel (2p right, 2p+1 left);  IR_en : one-hot emitter enable
//  LEDs      : error[11:4] of last sweep;  lft/rht : signed motor duties
module pid_motion_cntrl
  import motion_pkg::*;
#(
  parameter int unsigned N_PAIRS    = 3,
  parameter int unsigned SETTLE_CYC = 4096,
  parameter int unsigned GAP_CYC    = 32,
  parameter int unsigned WT_SHIFT   = 1,
  parameter int unsigned P_GAIN     = 2,
`ifdef MOTION_INTG_EN
  parameter int unsigned I_GAIN     = 1,
  parameter int unsigned INTG_DIV   = 4,
`endif
  parameter logic signed [MTR_W-1:0] MTR_BASE = 11'sh200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  output logic                    strt_cnv,
  input  logic                    cnv_cmplt,
  output logic [2:0]              chnnl,
  input  logic [RES_W-1:0]        A2D_res,
  output logic [N_PAIRS-1:0]      IR_en,
  output logic [7:0]              LEDs,
  output logic signed [MTR_W-1:0] lft,
  output logic signed [MTR_W-1:0] rht
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned P_W     = 2;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [P_W-1:0]    P_LAST      = P_W'(N_PAIRS - 1);
  localparam logic [GAIN_W-1:0] P_GAIN_C    = GAIN_W'(P_GAIN);
`ifdef MOTION_INTG_EN
  localparam logic [GAIN_W-1:0] I_GAIN_C    = GAIN_W'(I_GAIN);
  localparam int unsigned       SWP_W       = (INTG_DIV > 1) ? $clog2(INTG_DIV) : 1;
  localparam logic [SWP_W-1:0]  SWP_LAST    = SWP_W'(INTG_DIV - 1);
`endif

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [P_W-1:0]           p, p_nxt;
  logic signed [ACC_W-1:0]  accum, accum_nxt;
  logic signed [ERR_W-1:0]  error, error_nxt;
  logic                     strt_nxt;
  logic [2:0]               chnnl_nxt;
  logic [N_PAIRS-1:0]       ir_en_nxt;
  logic [7:0]               leds_nxt;
  logic signed [MTR_W-1:0]  lft_nxt, rht_nxt;

  logic signed [ERR_W-1:0]  mul_a_c;
  logic [GAIN_W-1:0]        mul_b_c;
  logic signed [PROD_W-1:0] mul_prod;

  logic [4:0]               shamt_c;
  logic signed [31:0]       wt_res_c;
  logic signed [ERR_W-1:0]  err_c;
  logic signed [31:0]       pi_sum_c;
  logic signed [ERR_W-1:0]  corr_c;

`ifdef MOTION_INTG_EN
  logic                     ph, ph_nxt;
  logic signed [ERR_W-1:0]  intgrl, intgrl_nxt;
  logic [SWP_W-1:0]         swp_cnt, swp_nxt;
  logic signed [PROD_W-1:0] p_hold, p_hold_nxt;
`endif

  pi_mul u_pi_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (mul_a_c),
    .b     (mul_b_c),
    .prod  (mul_prod)
  );

  // Weighted conversion result for the current pair.
  assign shamt_c  = 5'(32'(p) * WT_SHIFT);
  assign wt_res_c = $signed(32'(A2D_res) << shamt_c);
  assign err_c    = sat12(32'(accum));

  // P term is held from the first multiply; I term is the live product in MTR.
`ifdef MOTION_INTG_EN
  assign pi_sum_c = 32'(p_hold) + 32'(mul_prod);
`else
  assign pi_sum_c = 32'(mul_prod);
`endif
  assign corr_c = sat12(pi_sum_c);

  // Next-state and datapath/output next values.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    p_nxt     = p;
    accum_nxt = accum;
    error_nxt = error;
    strt_nxt  = 1'b0;
    chnnl_nxt = chnnl;
    ir_en_nxt = IR_en;
    leds_nxt  = LEDs;
    lft_nxt   = lft;
    rht_nxt   = rht;
    mul_a_c   = error;
    mul_b_c   = P_GAIN_C;
`ifdef MOTION_INTG_EN
    ph_nxt     = ph;
    intgrl_nxt = intgrl;
    swp_nxt    = swp_cnt;
    p_hold_nxt = p_hold;
`endif

    case (state)
      ST_IDLE: begin
        if (go) begin
          accum_nxt = '0;
          p_nxt     = '0;
          cnt_nxt   = '0;
          ir_en_nxt = N_PAIRS'(1);
          state_nxt = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          strt_nxt  = 1'b1;
          chnnl_nxt = {p, 1'b0};
          state_nxt = ST_CNV_R;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_CNV_R: begin
        if (cnv_cmplt) begin
          accum_nxt = sat_acc(32'(accum) - wt_res_c);
          state_nxt = ST_GAP;
        end
      end

      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          strt_nxt  = 1'b1;
          chnnl_nxt = {p, 1'b1};
          state_nxt = ST_CNV_L;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_CNV_L: begin
        if (cnv_cmplt) begin
          accum_nxt = sat_acc(32'(accum) + wt_res_c);
          ir_en_nxt = '0;
          state_nxt = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (p == P_LAST) begin
          error_nxt = err_c;
          leds_nxt  = err_c[ERR_W-1:4];
          state_nxt = ST_PI_MUL;
`ifdef MOTION_INTG_EN
          ph_nxt = 1'b0;
          // Integrator only absorbs the error once every INTG_DIV sweeps.
          if (swp_cnt == SWP_LAST) begin
            swp_nxt    = '0;
            intgrl_nxt = sat12(32'(intgrl) + 32'(err_c >>> 4));
          end else begin
            swp_nxt = swp_cnt + SWP_W'(1);
          end
`endif
        end else begin
          p_nxt     = p + P_W'(1);
          ir_en_nxt = N_PAIRS'(1) << (p + P_W'(1));
          state_nxt = ST_SETTLE;
        end
      end

      ST_PI_MUL: begin
`ifdef MOTION_INTG_EN
        // Phase 0 multiplies error*P, phase 1 intgrl*I while capturing P.
        if (!ph) begin
          ph_nxt = 1'b1;
        end else begin
          mul_a_c    = intgrl;
          mul_b_c    = I_GAIN_C;
          p_hold_nxt = mul_prod;
          state_nxt  = ST_MTR;
        end
`else
        state_nxt = ST_MTR;
`endif
      end

      ST_MTR: begin
        lft_nxt   = sat11(32'(MTR_BASE) + 32'(corr_c >>> 1));
        rht_nxt   = sat11(32'(MTR_BASE) - 32'(corr_c >>> 1));
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      p        <= '0;
      accum    <= '0;
      error    <= '0;
      strt_cnv <= 1'b0;
      chnnl    <= '0;
      IR_en    <= '0;
      LEDs     <= '0;
      lft      <= '0;
      rht      <= '0;
`ifdef MOTION_INTG_EN
      ph       <= 1'b0;
      intgrl   <= '0;
      swp_cnt  <= '0;
      p_hold   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      p        <= p_nxt;
      accum    <= accum_nxt;
      error    <= error_nxt;
      strt_cnv <= strt_nxt;
      chnnl    <= chnnl_nxt;
      IR_en    <= ir_en_nxt;
      LEDs     <= leds_nxt;
      lft      <= lft_nxt;
      rht      <= rht_nxt;
`ifdef MOTION_INTG_EN
      ph       <= ph_nxt;
      intgrl   <= intgrl_nxt;
      swp_cnt  <= swp_nxt;
      p_hold   <= p_hold_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pid_motion_cntrl.sv
// Self-checking bench for pid_motion_cntrl: A2D responder with random latency and
// stray cnv_cmplt pulses, arithmetic reference model of one sweep, directed and random sweeps.
module tb_pid_motion_cntrl;

  localparam int N      = 3;
  localparam int SETTLE = 64;
  localparam int GAP    = 8;
  localparam int KP     = 2;
`ifdef MOTION_INTG_EN
  localparam int KI     = 1;
  localparam int DIV    = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        strt_cnv;
  logic        cnv_cmplt = 1'b0;
  logic [2:0]  chnnl;
  logic [11:0] A2D_res = '0;
  logic [N-1:0] IR_en;
  logic [7:0]  LEDs;
  logic [10:0] lft;
  logic [10:0] rht;

  always #5 clk = ~clk;

  pid_motion_cntrl #(
    .N_PAIRS    (N),
    .SETTLE_CYC (SETTLE),
    .GAP_CYC    (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .strt_cnv  (strt_cnv),
    .cnv_cmplt (cnv_cmplt),
    .chnnl     (chnnl),
    .A2D_res   (A2D_res),
    .IR_en     (IR_en),
    .LEDs      (LEDs),
    .lft       (lft),
    .rht       (rht)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] chan_val [8];
  int m_intgrl = 0;
  int m_swp    = 0;

  function automatic int sat(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_sweep(output logic [10:0] e_lft, output logic [10:0] e_rht,
                             output logic [7:0] e_leds);
    int acc, err, corr, half, iterm;
    acc = 0;
    for (int p = 0; p < N; p++) begin
      acc = sat(acc - (int'(chan_val[2*p])   << p), -32768, 32767);
      acc = sat(acc + (int'(chan_val[2*p+1]) << p), -32768, 32767);
    end
    err    = sat(acc, -2048, 2047);
    e_leds = 8'(err >>> 4);
    iterm  = 0;
`ifdef MOTION_INTG_EN
    m_swp++;
    if (m_swp == DIV) begin
      m_swp    = 0;
      m_intgrl = sat(m_intgrl + (err >>> 4), -2048, 2047);
    end
    iterm = m_intgrl * KI;
`endif
    corr  = sat(err * KP + iterm, -2048, 2047);
    half  = corr >>> 1;
    e_lft = 11'(sat(512 + half, -1024, 1023));
    e_rht = 11'(sat(512 - half, -1024, 1023));
  endtask

  // ---------------- A2D responder and protocol monitor ----------------
  int          cyc = 0;
  int          done_cnt = 0;
  int          strt_cnt = 0;
  int          ir_rise_cyc = 0;
  int          done_cyc = 0;
  logic [N-1:0] ir_prev = '0;
  bit          pending = 1'b0;
  int          lat = 0;
  logic [2:0]  pend_ch = '0;
  logic [2:0]  ch_log [$];

  always @(negedge clk) begin
    cyc++;
    cnv_cmplt = 1'b0;
    if (!rst_n) begin
      pending = 1'b0;
      ir_prev = '0;
    end else begin
      if (IR_en != '0 && ir_prev == '0) ir_rise_cyc = cyc;
      ir_prev = IR_en;
      if (strt_cnv) begin
        chk("strt_while_pending", 32'(pending), 32'd0);
        chk("ir_en_onehot", 32'(IR_en), 32'd1 << chnnl[2:1]);
        if (!chnnl[0]) chk("settle_lat", 32'(cyc - ir_rise_cyc), 32'(SETTLE));
        else           chk("gap_lat", 32'(cyc - done_cyc), 32'(GAP + 1));
        strt_cnt++;
        ch_log.push_back(chnnl);
        pending = 1'b1;
        pend_ch = chnnl;
        lat     = int'($urandom_range(0, 6));
      end else if (pending) begin
        if (lat == 0) begin
          cnv_cmplt = 1'b1;
          A2D_res   = chan_val[pend_ch];
          pending   = 1'b0;
          done_cnt++;
          done_cyc  = cyc;
        end else begin
          lat--;
          A2D_res = 12'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // Stray completion while no conversion is outstanding must be ignored.
        cnv_cmplt = 1'b1;
        A2D_res   = 12'($urandom);
      end
    end
  end

  // ---------------- sweep driver ----------------
  task automatic set_chan(input logic [11:0] rgt, input logic [11:0] lf);
    for (int p = 0; p < N; p++) begin
      chan_val[2*p]   = rgt;
      chan_val[2*p+1] = lf;
    end
  endtask

  task automatic do_sweep(input string tag);
    int start, base, n;
    logic [10:0] el, er;
    logic [7:0]  eled;
    start = done_cnt;
    base  = ch_log.size();
    go = 1'b1;
    repeat (2) @(negedge clk);
    go = 1'b0;
    n = 0;
    while (done_cnt < start + 2*N && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_convs"}, 32'(done_cnt - start), 32'(2*N));
    repeat (10) @(negedge clk);
    model_sweep(el, er, eled);
    chk({tag, "_lft"}, 32'(lft), 32'(el));
    chk({tag, "_rht"}, 32'(rht), 32'(er));
    chk({tag, "_leds"}, 32'(LEDs), 32'(eled));
    chk({tag, "_nstrt"}, 32'(ch_log.size() - base), 32'(2*N));
    for (int i = 0; i < 2*N && base + i < ch_log.size(); i++)
      chk({tag, "_chnnl"}, 32'(ch_log[base+i]), 32'(i));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, ir_hi, n;
    for (int i = 0; i < 8; i++) chan_val[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ir_en", 32'(IR_en), 32'd0);
    chk("rst_strt", 32'(strt_cnv), 32'd0);
    chk("rst_chnnl", 32'(chnnl), 32'd0);
    chk("rst_leds", 32'(LEDs), 32'd0);
    chk("rst_lft", 32'(lft), 32'd0);
    chk("rst_rht", 32'(rht), 32'd0);
    rst_n = 1'b1;

    // go low: controller must stay idle despite stray completions.
    s = strt_cnt;
    ir_hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (IR_en != '0) ir_hi++;
    end
    chk("idle_strt", 32'(strt_cnt - s), 32'd0);
    chk("idle_ir", 32'(ir_hi), 32'd0);
    chk("idle_lft", 32'(lft), 32'd0);
    chk("idle_rht", 32'(rht), 32'd0);

    set_chan(12'h222, 12'h222); do_sweep("flat");
    set_chan(12'h000, 12'h010); do_sweep("left16");
    set_chan(12'h000, 12'hFFF); do_sweep("left_max");
    set_chan(12'hFFF, 12'h000); do_sweep("right_max");
    set_chan(12'h000, 12'h010);
    repeat (4) do_sweep("hold");

    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 8; c++) begin
        case (k % 3)
          0:       chan_val[c] = 12'($urandom);
          1:       chan_val[c] = c[0] ? 12'($urandom_range(0, 255)) : 12'($urandom_range(0, 63));
          default: chan_val[c] = c[0] ? 12'($urandom_range(0, 63)) : 12'($urandom_range(0, 255));
        endcase
      end
      do_sweep("rand");
    end

    // Reset while pair 1's left conversion is outstanding.
    set_chan(12'h000, 12'h010);
    go = 1'b1;
    n = 0;
    while (!(pending && pend_ch == 3'd3) && n < 5000) begin
      @(negedge clk);
      #2;
      n++;
    end
    go = 1'b0;
    chk("midrst_reached", 32'(pending && pend_ch == 3'd3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ir_en", 32'(IR_en), 32'd0);
    chk("midrst_strt", 32'(strt_cnv), 32'd0);
    chk("midrst_chnnl", 32'(chnnl), 32'd0);
    chk("midrst_leds", 32'(LEDs), 32'd0);
    chk("midrst_lft", 32'(lft), 32'd0);
    chk("midrst_rht", 32'(rht), 32'd0);
    m_intgrl = 0;
    m_swp    = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_sweep("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
